// File: rtl/jtag_bus_master.sv
// JTAG user-op executor driving a single-word req/ack bus.
// Optional macro JTAG_BUS_TIMEOUT_EN compiles in the bus timeout and its err path.
module jtag_bus_master #(
  parameter int DATA_LEN       = 32,
  parameter int ADDR_LEN       = 32,
  parameter int OP_LEN         = 8,
  parameter int ADDR_INC       = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                tck,
  input  logic                trst,
  input  logic [OP_LEN-1:0]   user_op,
  input  logic                user_op_ready,
  input  logic [DATA_LEN-1:0] user_wdata,
  output logic [DATA_LEN-1:0] user_rdata,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_LEN-1:0] bus_addr,
  output logic [DATA_LEN-1:0] bus_wdata,
  input  logic [DATA_LEN-1:0] bus_rdata,
  input  logic                bus_ack,
  output logic                busy
);

  typedef enum logic {S_IDLE, S_BUS} state_e;

  localparam int EXT_W = OP_LEN + 8;

  state_e              state_q, state_d;
  logic                rdy_prev_q, rdy_prev_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [DATA_LEN-1:0] wdata_q, wdata_d;
  logic [DATA_LEN-1:0] rdata_q, rdata_d;
  logic                we_q, we_d;
  logic                inc_q, inc_d;
  logic                err_q, err_d;
  logic                ovr_q, ovr_d;
  logic                sel_q, sel_d;
  logic [7:0]          last_op_q, last_op_d;
`ifdef JTAG_BUS_TIMEOUT_EN
  logic [15:0]         tmo_cnt_q, tmo_cnt_d;
`endif

  logic [EXT_W-1:0]    op_ext;
  logic [7:0]          op8;
  logic                accept, op_valid, done, timeout;
  logic [DATA_LEN-1:0] status;

  assign op_ext   = {8'b0, user_op};
  assign op8      = op_ext[7:0];
  assign op_valid = (op_ext < EXT_W'(8));
  assign accept   = user_op_ready & ~rdy_prev_q;

  always_comb begin
    state_d   = state_q;
    rdy_prev_d = user_op_ready;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    we_d      = we_q;
    inc_d     = inc_q;
    err_d     = err_q;
    ovr_d     = ovr_q;
    sel_d     = sel_q;
    last_op_d = last_op_q;
    done      = 1'b0;
    timeout   = 1'b0;
`ifdef JTAG_BUS_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept && op_valid) begin
          last_op_d = op8;
          sel_d     = (op8 == 8'h06);
          case (op8)
            8'h01: addr_d = ADDR_LEN'(user_wdata);
            8'h02, 8'h03, 8'h04, 8'h05: begin
              state_d = S_BUS;
              we_d    = (op8 == 8'h02) || (op8 == 8'h04);
              inc_d   = (op8 == 8'h04) || (op8 == 8'h05);
              if ((op8 == 8'h02) || (op8 == 8'h04)) wdata_d = user_wdata;
`ifdef JTAG_BUS_TIMEOUT_EN
              tmo_cnt_d = '0;
`endif
            end
            8'h07: begin
              err_d = 1'b0;
              ovr_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      S_BUS: begin
        // Anything arriving mid-transaction is dropped, SET_ADDR included.
        if (accept && op_valid) ovr_d = 1'b1;
        if (bus_ack) begin
          done = 1'b1;
        end else begin
`ifdef JTAG_BUS_TIMEOUT_EN
          if (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            done    = 1'b1;
            timeout = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
          end
`endif
        end
        if (done) begin
          state_d = S_IDLE;
          if (!we_q) rdata_d = timeout ? '1 : bus_rdata;
          if (inc_q) addr_d = addr_q + ADDR_LEN'(ADDR_INC);
          if (timeout) err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge tck) begin
    if (!trst) begin
      state_q    <= S_IDLE;
      rdy_prev_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      we_q       <= 1'b0;
      inc_q      <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
      sel_q      <= 1'b0;
      last_op_q  <= '0;
`ifdef JTAG_BUS_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rdy_prev_q <= rdy_prev_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      we_q       <= we_d;
      inc_q      <= inc_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
      sel_q      <= sel_d;
      last_op_q  <= last_op_d;
`ifdef JTAG_BUS_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
`endif
    end
  end

  always_comb begin
    status       = '0;
    status[0]    = (state_q == S_BUS);
    status[1]    = err_q;
    status[2]    = ovr_q;
    status[15:8] = last_op_q;
  end

  assign busy       = (state_q == S_BUS);
  assign bus_req    = (state_q == S_BUS);
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign user_rdata = sel_q ? status : rdata_q;

endmodule

// File: tb/tb_jtag_bus_master.sv
// Directed bench for jtag_bus_master: scoreboarded bus transactions plus status checks.
module tb_jtag_bus_master;
  logic        tck = 1'b0;
  logic        trst = 1'b0;
  logic [7:0]  user_op = '0;
  logic        user_op_ready = 1'b0;
  logic [31:0] user_wdata = '0;
  logic [31:0] user_rdata;
  logic        bus_req, bus_we, busy;
  logic [31:0] bus_addr, bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  always #5 tck = ~tck;

  jtag_bus_master #(.DATA_LEN(32), .ADDR_LEN(32), .OP_LEN(8), .ADDR_INC(4), .TIMEOUT_CYCLES(8)) dut (
    .tck(tck), .trst(trst), .user_op(user_op), .user_op_ready(user_op_ready),
    .user_wdata(user_wdata), .user_rdata(user_rdata), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .busy(busy)
  );

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata;} txn_t;
  txn_t        exp_q[$];
  logic [31:0] rd_q[$];
  int n_tests = 0, n_fail = 0;
  int txn_cnt = 0, last_burst = 0;
  bit ack_en = 1'b1, stray_ack = 1'b0;
  int ack_dly = 0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [7:0] op, input logic [31:0] wd);
    @(negedge tck);
    user_op = op; user_wdata = wd; user_op_ready = 1'b1;
    @(negedge tck);
    user_op_ready = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max && busy; i++) @(negedge tck);
    n_tests++;
    assert (!busy) else begin
      n_fail++;
      $error("FAIL wait_idle: busy=%0b after %0d cycles, want 0", busy, max);
    end
    @(negedge tck);
  endtask

  // Bus slave: acks ack_dly cycles after bus_req, returning queued read data.
  initial begin
    int cnt = 0;
    bus_ack = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge tck);
      bus_ack = 1'b0;
      if (stray_ack) begin
        bus_ack = 1'b1; stray_ack = 1'b0;
      end else if (bus_req && ack_en) begin
        if (cnt >= ack_dly) begin
          bus_ack = 1'b1;
          bus_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  // Monitor: pops the scoreboard at each transaction start, checks hold and ack response.
  initial begin
    bit prev = 1'b0, acked;
    int burst = 0;
    txn_t cur = '0, e;
    forever begin
      @(posedge tck);
      acked = bus_ack && bus_req && trst;
      #1;
      if (acked) begin
        check("req_drop_after_ack", 96'(bus_req), 96'(0));
        check("busy_drop_after_ack", 96'(busy), 96'(0));
      end
      if (bus_req && !prev) begin
        txn_cnt++; burst = 0;
        cur = '{bus_we, bus_addr, bus_wdata};
        n_tests++;
        assert (exp_q.size() > 0) else begin
          n_fail++;
          $error("FAIL unexpected_txn: got we=%0b addr=%0h, want no transaction", bus_we, bus_addr);
        end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("txn_we", 96'(bus_we), 96'(e.we));
          check("txn_addr", 96'(bus_addr), 96'(e.addr));
          if (e.we) check("txn_wdata", 96'(bus_wdata), 96'(e.wdata));
        end
      end else if (bus_req && prev) begin
        check("txn_stable", 96'({bus_we, bus_addr, bus_wdata}), 96'(cur));
      end
      if (bus_req) burst++;
      else if (prev) last_burst = burst;
      prev = bus_req;
    end
  end

  initial begin
    int t0;
    // Reset
    repeat (3) @(negedge tck);
    check("rst_user_rdata", 96'(user_rdata), 96'(0));
    check("rst_bus_req", 96'(bus_req), 96'(0));
    check("rst_busy", 96'(busy), 96'(0));
    check("rst_bus_we", 96'(bus_we), 96'(0));
    check("rst_bus_addr", 96'(bus_addr), 96'(0));
    check("rst_bus_wdata", 96'(bus_wdata), 96'(0));
    trst = 1'b1;

    // SET_ADDR then WRITE
    ack_dly = 2; t0 = txn_cnt;
    cmd(8'h01, 32'h1000);
    exp_q.push_back('{1'b1, 32'h1000, 32'hCAFEF00D});
    cmd(8'h02, 32'hCAFEF00D);
    check("wr_req_latency", 96'(bus_req), 96'(1));
    check("wr_busy", 96'(busy), 96'(1));
    wait_idle(50);
    check("wr_one_txn", 96'(txn_cnt - t0), 96'(1));

    // READ_INC x3 across the address wrap, then plain READ at the wrapped address
    ack_dly = 0;
    cmd(8'h01, 32'hFFFF_FFF8);
    rd_q.push_back(32'h11); rd_q.push_back(32'h22); rd_q.push_back(32'h33); rd_q.push_back(32'h44);
    exp_q.push_back('{1'b0, 32'hFFFF_FFF8, 32'h0});
    cmd(8'h05, 32'h0); wait_idle(50);
    check("rinc1_rdata", 96'(user_rdata), 96'(32'h11));
    exp_q.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0});
    cmd(8'h05, 32'h0); wait_idle(50);
    check("rinc2_rdata", 96'(user_rdata), 96'(32'h22));
    exp_q.push_back('{1'b0, 32'h0000_0000, 32'h0});
    cmd(8'h05, 32'h0); wait_idle(50);
    check("rinc3_rdata", 96'(user_rdata), 96'(32'h33));
    exp_q.push_back('{1'b0, 32'h0000_0004, 32'h0});
    cmd(8'h03, 32'h0); wait_idle(50);
    check("rd_after_wrap", 96'(user_rdata), 96'(32'h44));

`ifdef JTAG_BUS_TIMEOUT_EN
    // READ timeout
    ack_en = 1'b0;
    exp_q.push_back('{1'b0, 32'h0000_0004, 32'h0});
    cmd(8'h03, 32'h0); wait_idle(100);
    check("tmo_req_cycles", 96'(last_burst), 96'(8));
    check("tmo_rdata", 96'(user_rdata), 96'(32'hFFFF_FFFF));
    cmd(8'h06, 32'h0);
    check("tmo_status", 96'(user_rdata), 96'(32'h0000_0602));
    cmd(8'h07, 32'h0);
    ack_en = 1'b1;
`endif

    // Overrun: READ while WRITE in flight is dropped
    ack_dly = 5; t0 = txn_cnt;
    exp_q.push_back('{1'b1, 32'h0000_0004, 32'h55});
    cmd(8'h02, 32'h55);
    cmd(8'h03, 32'h0);
    check("ovr_still_busy", 96'(busy), 96'(1));
    wait_idle(50);
    check("ovr_one_txn", 96'(txn_cnt - t0), 96'(1));
    cmd(8'h06, 32'h0);
    check("ovr_status", 96'(user_rdata), 96'(32'h0000_0604));
    cmd(8'h07, 32'h0);
    cmd(8'h06, 32'h0);
    check("clr_status", 96'(user_rdata), 96'(32'h0000_0600));

    // Reset mid-transaction, then a stray ack
    ack_en = 1'b0;
    exp_q.push_back('{1'b1, 32'h0000_0004, 32'h99});
    cmd(8'h02, 32'h99);
    check("mrst_req_before", 96'(bus_req), 96'(1));
    trst = 1'b0;
    @(negedge tck);
    trst = 1'b1;
    check("mrst_bus_req", 96'(bus_req), 96'(0));
    check("mrst_busy", 96'(busy), 96'(0));
    check("mrst_bus_addr", 96'(bus_addr), 96'(0));
    check("mrst_user_rdata", 96'(user_rdata), 96'(0));
    t0 = txn_cnt;
    stray_ack = 1'b1;
    repeat (3) @(negedge tck);
    check("stray_ack_busy", 96'(busy), 96'(0));
    check("stray_ack_rdata", 96'(user_rdata), 96'(0));
    check("stray_ack_no_txn", 96'(txn_cnt - t0), 96'(0));
    ack_en = 1'b1;

    // Level-held ready gives one transaction
    ack_dly = 1; t0 = txn_cnt;
    exp_q.push_back('{1'b1, 32'h0, 32'h77});
    @(negedge tck);
    user_op = 8'h02; user_wdata = 32'h77; user_op_ready = 1'b1;
    repeat (10) @(negedge tck);
    user_op_ready = 1'b0;
    wait_idle(50);
    check("hold_one_txn", 96'(txn_cnt - t0), 96'(1));

    // Unknown op is ignored entirely
    cmd(8'h06, 32'h0);
    t0 = txn_cnt;
    cmd(8'hA5, 32'hFFFF);
    repeat (3) @(negedge tck);
    check("bad_op_busy", 96'(busy), 96'(0));
    check("bad_op_no_txn", 96'(txn_cnt - t0), 96'(0));
    check("bad_op_status", 96'(user_rdata), 96'(32'h0000_0600));
    check("exp_drained", 96'(exp_q.size()), 96'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
